bky_load_sched: RTL and testbench
=================================

# bky_load_sched

Scheduler and counter datapath for the bucky-load shifter sequencer. It arbitrates between two load requesters (A, B) and drives the sequencer's START. It supplies the sequencer's bit counter CNT and word counter LOOP, which are advanced from the sequencer's RDENA/SHFT_ENA/CLR_CNT strobes. It supervises FIFO starvation with a timeout that resets the sequencer and reports an error.

## Interface
- NWORDS, 19: words per load; the sequencer finishes when LOOP = NWORDS-1 at CNT = 15.
- TMO, 1023: consecutive MT-high cycles tolerated while waiting for data before abort (10-bit timer).

Ports:
- CLK  in  1  clock; all registers update on falling edge (matches sequencer).
- RST  in  1  reset RST, asynchronous, active-high.
- REQ_A, REQ_B  in  1  level requests; held until own ACK.
- ACK_A, ACK_B  out  1  one-cycle completion pulse to owner.
- OWNER  out  1  current/last grantee (0 = A, 1 = B).
- BUSY  out  1  high from grant until ACK cycle inclusive.
- ERR  out  1  sticky timeout flag; cleared at next grant.
- START  out  1  to sequencer.
- LDR_RST  out  1  one-cycle sequencer reset pulse on abort.
- CLR_CNT, RDENA, SHFT_ENA, SET_DONE  in  1  sequencer strobes.
- MT  in  1  source FIFO empty.
- CNT  out  4  bit counter to sequencer.
- LOOP  out  5  word counter to sequencer.

## Operation
- States: IDLE, LOAD, RELEASE, ABORT, ACK, WAITREL.
- IDLE:
  - If any REQ is high, grant it and go to LOAD.
  - If both are high, grant the requester not equal to OWNER (round-robin).
  - OWNER resets to 1, so A wins the first contest.
  - On grant: set OWNER, clear ERR, clear timer, assert START and BUSY.
- LOAD:
  - START stays high.
  - If SET_DONE = 1, go to RELEASE.
  - Else if the timer reaches TMO, go to ABORT.
  - The timer counts cycles with MT = 1 and RDENA = 0, and clears on any cycle with MT = 0. It only counts until the first RDENA of the load; after that, starvation is impossible by construction of the sequencer.
- RELEASE:
  - START = 0; wait for SET_DONE = 0 (sequencer back in Idle), then go to ACK.
- ABORT:
  - START = 0, LDR_RST = 1 for exactly one cycle, ERR set; next state ACK.
- ACK:
  - Pulse ACK of OWNER for one cycle, then go to WAITREL.
- WAITREL:
  - BUSY = 0; wait for REQ of OWNER low, then go to IDLE.
  - A request held past ACK is never re-served without first being seen low.
- Counters:
  - CNT and LOOP clear to 0 on CLR_CNT, on LDR_RST and in IDLE.
  - CNT increments by 1 on each SHFT_ENA cycle and wraps 15 -> 0.
  - LOOP increments on SHFT_ENA when CNT = 15, and saturates at 31.
  - CLR_CNT has priority over increment.
- RDENA is ignored by the counters; it is used only for the timer rule.
- Reset values: all outputs 0 except OWNER = 1; state IDLE; timer 0.
- RST mid-load returns to IDLE. No ACK is issued and ERR is cleared; the requester must re-request.

## Timing
- Grant: REQ sampled high at falling edge N makes START high after edge N. The sequencer enters Wait4Data at edge N+1.
- Word cadence: one Read cycle plus 16 Shift cycles, i.e. 17 cycles per word.
- Full load: NWORDS×17 = 323 cycles from first Read to Set_Done, with MT continuously low.
- Completion: SET_DONE high -> START low next cycle. SET_DONE low (one cycle later) -> ACK pulse at the following edge.
- Abort: timer = TMO -> LDR_RST high for exactly one cycle, then ACK the cycle after. ERR stays high until the next grant.
- Requests arriving during BUSY are held pending. They are evaluated in IDLE only, one cycle after WAITREL exits.
- Simultaneous owner-REQ drop and other-REQ rise in WAITREL: the other requester is granted on the next IDLE cycle.

## Test plan
- REQ_A only, MT low: START at +1 cycle. 19 RDENA pulses with CNT sweeping 0..15 each word and LOOP 0..18. Then ACK_A one cycle; ERR = 0.
- REQ_A and REQ_B high at the same edge after reset: A is granted first. After A's ACK and REQ_A drop, B is granted; OWNER = 1.
- A and B continuously re-request: grants alternate A, B, A, B. No requester is served twice in a row while the other is pending.
- MT held high after grant with TMO = 1023: LDR_RST pulses at cycle 1023, ERR = 1, and the owner's ACK follows one cycle later. The next grant clears ERR.
- REQ_A held high after ACK_A: no second grant until REQ_A is low for at least one cycle.
- RST asserted mid-load at LOOP = 7: all outputs zero immediately, OWNER = 1, no ACK issued. After release, a new request completes normally.

Source files
------------

// File: rtl/bky_load_sched_if.sv
// Handshake and strobe bundle between the load scheduler and its requesters/sequencer.
interface bky_load_sched_if;
    logic       REQ_A, REQ_B;
    logic       ACK_A, ACK_B;
    logic       OWNER, BUSY, ERR;
    logic       START, LDR_RST;
    logic       CLR_CNT, RDENA, SHFT_ENA, SET_DONE, MT;
    logic [3:0] CNT;
    logic [4:0] LOOP;

    modport slave (
        input  REQ_A, REQ_B, CLR_CNT, RDENA, SHFT_ENA, SET_DONE, MT,
        output ACK_A, ACK_B, OWNER, BUSY, ERR, START, LDR_RST, CNT, LOOP
    );

    modport master (
        output REQ_A, REQ_B, CLR_CNT, RDENA, SHFT_ENA, SET_DONE, MT,
        input  ACK_A, ACK_B, OWNER, BUSY, ERR, START, LDR_RST, CNT, LOOP
    );
endinterface

// File: rtl/bky_load_sched.sv
// Two-requester round-robin scheduler for the bucky-load sequencer, with its
// bit/word counters and a FIFO-starvation abort timer. All state moves on the falling edge.
module bky_load_sched #(
    parameter int TMO = 1023
) (
    input logic            CLK,
    input logic            RST,
    bky_load_sched_if.slave bus
);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, ABORT, ACK, WAITREL} state_t;

    state_t        state, state_nxt;
    logic          owner, err, armed;
    logic [TW-1:0] timer;
    logic [3:0]    cnt;
    logic [4:0]    loop;
    logic          grant_b, owner_req, starve, tmo_hit, ldr_rst;

    assign grant_b   = (bus.REQ_A && bus.REQ_B) ? ~owner : bus.REQ_B;
    assign owner_req = owner ? bus.REQ_B : bus.REQ_A;
    // Starvation only counts before the first read of the load.
    assign starve    = armed && bus.MT && !bus.RDENA;
    assign tmo_hit   = starve && (timer == TW'(TMO - 1));
    assign ldr_rst   = (state == ABORT);

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.REQ_A || bus.REQ_B) state_nxt = LOAD;
            LOAD: begin
                if (bus.SET_DONE)  state_nxt = RELEASE;
                else if (tmo_hit)  state_nxt = ABORT;
            end
            RELEASE: if (!bus.SET_DONE) state_nxt = ACK;
            ABORT:   state_nxt = ACK;
            ACK:     state_nxt = WAITREL;
            WAITREL: if (!owner_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            owner <= 1'b1;
            err   <= 1'b0;
            timer <= '0;
            armed <= 1'b0;
        end else if (state == IDLE && state_nxt == LOAD) begin
            owner <= grant_b;
            err   <= 1'b0;
            timer <= '0;
            armed <= 1'b1;
        end else if (state == LOAD) begin
            if (bus.RDENA)    armed <= 1'b0;
            if (!bus.MT)      timer <= '0;
            else if (starve)  timer <= timer + 1'b1;
            if (state_nxt == ABORT) err <= 1'b1;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            loop <= '0;
        end else if (state == IDLE || bus.CLR_CNT || ldr_rst) begin
            cnt  <= '0;
            loop <= '0;
        end else if (bus.SHFT_ENA) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15 && loop != 5'd31) loop <= loop + 5'd1;
        end
    end

    assign bus.START   = (state == LOAD);
    assign bus.BUSY    = (state == LOAD) || (state == RELEASE) || (state == ABORT) || (state == ACK);
    assign bus.LDR_RST = ldr_rst;
    assign bus.ACK_A   = (state == ACK) && !owner;
    assign bus.ACK_B   = (state == ACK) && owner;
    assign bus.OWNER   = owner;
    assign bus.ERR     = err;
    assign bus.CNT     = cnt;
    assign bus.LOOP    = loop;
endmodule

// File: tb/tb_bky_load_sched.sv
// Directed bench for bky_load_sched: grant/abort/ack events are scoreboarded by a monitor.
module tb_bky_load_sched;
    localparam int K_GRANT = 0, K_ABORT = 1, K_ACK = 2;

    typedef struct {
        int   kind;
        logic owner;
        logic err;
        int   tm;   // grant: absolute cycle; abort/ack: cycles since previous event; -1 = any
    } exp_t;

    logic clk, rst;
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, last_ev = 0;
    exp_t q[$];

    bky_load_sched_if bus();
    bky_load_sched dut (.CLK(clk), .RST(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic o, input logic e, input int t);
        exp_t x;
        x.kind = k; x.owner = o; x.err = e; x.tm = t;
        q.push_back(x);
    endtask

    task automatic ev(input int k);
        exp_t e;
        int   dt;
        logic own, ok;
        own = (k == K_ACK) ? bus.ACK_B : bus.OWNER;
        dt  = (k == K_GRANT) ? cyc : cyc - last_ev;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: kind %0d at cyc %0d, expected no event", k, cyc);
        end else begin
            e  = q.pop_front();
            ok = (e.kind == k) && (e.owner == own) && (e.err == bus.ERR) && (e.tm < 0 || e.tm == dt);
            if (k == K_ACK && bus.ACK_A == bus.ACK_B) ok = 1'b0;
            if (!ok) begin
                miscompares++;
                $display("FAIL event: got kind %0d owner %0d err %0d time %0d, expected kind %0d owner %0d err %0d time %0d",
                         k, own, bus.ERR, dt, e.kind, e.owner, e.err, e.tm);
            end
        end
        last_ev = cyc;
    endtask

    // Monitor: outputs are stable at the rising edge (DUT updates on falling edge).
    initial begin
        logic start_q;
        start_q = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.START && !start_q)    ev(K_GRANT);
            if (bus.LDR_RST)              ev(K_ABORT);
            if (bus.ACK_A || bus.ACK_B)   ev(K_ACK);
            start_q = bus.START;
        end
    end

    task automatic wait_start(input int lim);
        int n = 0;
        while (!bus.START && n < lim) begin @(posedge clk); n++; end
        chk("start_seen", bus.START, 1);
    endtask

    task automatic wait_ack(input int lim);
        int n = 0;
        while (!(bus.ACK_A || bus.ACK_B) && n < lim) begin @(posedge clk); n++; end
        chk("ack_seen", bus.ACK_A | bus.ACK_B, 1);
    endtask

    // Plays the sequencer: per word one Read cycle then 16 Shift cycles.
    task automatic do_load(input int words, input int rst_word);
        wait_start(20);
        bus.CLR_CNT = 1'b1;
        @(posedge clk);
        bus.CLR_CNT = 1'b0;
        for (int w = 0; w < words; w++) begin
            bus.RDENA = 1'b1;
            @(posedge clk);
            bus.RDENA = 1'b0;
            for (int k = 0; k < 16; k++) begin
                chk("cnt", bus.CNT, k);
                chk("loop", bus.LOOP, w);
                if (w == rst_word && k == 0) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_ctrl_outs", {bus.START, bus.BUSY, bus.ACK_A, bus.ACK_B, bus.ERR, bus.LDR_RST}, 0);
                    chk("rst_cnt", bus.CNT, 0);
                    chk("rst_loop", bus.LOOP, 0);
                    chk("rst_owner", bus.OWNER, 1);
                    return;
                end
                bus.SHFT_ENA = 1'b1;
                @(posedge clk);
                bus.SHFT_ENA = 1'b0;
            end
        end
        bus.SET_DONE = 1'b1;
        @(posedge clk);
        bus.SET_DONE = 1'b0;
        chk("start_low_in_release", bus.START, 0);
        chk("busy_in_release", bus.BUSY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.REQ_A = 0; bus.REQ_B = 0; bus.CLR_CNT = 0; bus.RDENA = 0;
        bus.SHFT_ENA = 0; bus.SET_DONE = 0; bus.MT = 0;
        repeat (3) @(posedge clk);
        chk("reset_ctrl_outs", {bus.START, bus.BUSY, bus.ACK_A, bus.ACK_B, bus.ERR, bus.LDR_RST}, 0);
        chk("reset_cnt", bus.CNT, 0);
        chk("reset_loop", bus.LOOP, 0);
        chk("reset_owner", bus.OWNER, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Both request on the same edge, then keep re-requesting: A,B,A,B.
        bus.REQ_A = 1'b1; bus.REQ_B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(K_GRANT, 1'(i % 2), 1'b0, -1);
            push(K_ACK,   1'(i % 2), 1'b0, 17 * 1 + 3);
            do_load(1, -1);
            wait_ack(10);
            if (i == 3) begin
                bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
            end else begin
                if (i % 2 == 0) bus.REQ_A = 1'b0; else bus.REQ_B = 1'b0;
                repeat (2) @(posedge clk);
                if (i % 2 == 0) bus.REQ_A = 1'b1; else bus.REQ_B = 1'b1;
            end
        end
        repeat (3) @(posedge clk);

        // Full 19-word load for A with MT low.
        push(K_GRANT, 1'b0, 1'b0, cyc + 1);
        push(K_ACK,   1'b0, 1'b0, 17 * 19 + 3);
        bus.REQ_A = 1'b1;
        do_load(19, -1);
        wait_ack(10);

        // A held past its ACK: must not be re-served until seen low.
        repeat (20) @(posedge clk);
        chk("held_req_not_regranted", bus.BUSY, 0);
        bus.REQ_A = 1'b0;
        @(posedge clk);
        push(K_GRANT, 1'b0, 1'b0, -1);
        push(K_ACK,   1'b0, 1'b0, 17 * 1 + 3);
        bus.REQ_A = 1'b1;
        do_load(1, -1);
        wait_ack(10);
        bus.REQ_A = 1'b0;
        repeat (3) @(posedge clk);

        // Starvation: MT high from grant, abort after TMO cycles.
        bus.MT = 1'b1;
        push(K_GRANT, 1'b1, 1'b0, cyc + 1);
        push(K_ABORT, 1'b1, 1'b1, 1023);
        push(K_ACK,   1'b1, 1'b1, 1);
        bus.REQ_B = 1'b1;
        wait_ack(1100);
        bus.REQ_B = 1'b0;
        bus.MT = 1'b0;
        repeat (5) @(posedge clk);
        chk("err_sticky", bus.ERR, 1);
        chk("cnt_after_abort", bus.CNT, 0);
        push(K_GRANT, 1'b0, 1'b0, cyc + 1);
        push(K_ACK,   1'b0, 1'b0, 17 * 1 + 3);
        bus.REQ_A = 1'b1;
        do_load(1, -1);
        wait_ack(10);
        bus.REQ_A = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-load at LOOP = 7, then a normal load.
        push(K_GRANT, 1'b0, 1'b0, cyc + 1);
        bus.REQ_A = 1'b1;
        do_load(19, 7);
        bus.REQ_A = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        chk("owner_after_rst", bus.OWNER, 1);
        push(K_GRANT, 1'b0, 1'b0, cyc + 1);
        push(K_ACK,   1'b0, 1'b0, 17 * 2 + 3);
        bus.REQ_A = 1'b1;
        do_load(2, -1);
        wait_ack(10);
        bus.REQ_A = 1'b0;
        repeat (5) @(posedge clk);

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
